// File: rtl/bcd_gate_ctrl_if.sv
// Bundle between bcd_gate_ctrl, its two-digit counter, and the control/readout side.
// The master side drives the control inputs; the slave side is the controller.
interface bcd_gate_ctrl_if;
    logic       start;
    logic       stop;
    logic       ev;
    logic [7:0] limit;
    logic [7:0] cnt_val;
    logic       cnt_x;
    logic       cnt_clr;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ack;
    logic       hit;
    logic       ovf;

    modport master (
        output start, stop, ev, limit, cnt_val, rd_ack,
        input  cnt_x, cnt_clr, busy, rd_data, rd_valid, hit, ovf
    );

    modport slave (
        input  start, stop, ev, limit, cnt_val, rd_ack,
        output cnt_x, cnt_clr, busy, rd_data, rd_valid, hit, ovf
    );
endinterface

// File: rtl/bcd_gate_ctrl.sv
// Gated event counter controller: opens a window on start, drives an external 0..99
// counter until the limit or stop, then holds the final count until acknowledged.
module bcd_gate_ctrl (
    input  logic             clk,
    input  logic             reset,
    bcd_gate_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(99);

    typedef enum logic [1:0] {IDLE, CLR, RUN, REPORT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             hit_q, hit_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             lim_hit_c;
    logic             cnt_x_c;

    // Limit match only applies to limits in counter range; larger limits never match.
    always_comb begin
        lim_hit_c = (state_q == RUN) && (limit_q <= CNT_MAX) && (bus.cnt_val == limit_q);
        cnt_x_c   = (state_q == RUN) && bus.ev && !bus.stop && (bus.cnt_val != limit_q);

        state_d    = state_q;
        limit_d    = limit_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        hit_d      = hit_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLR;
                    limit_d = bus.limit;
                    busy_d  = 1'b1;
                end
            end
            CLR: begin
                state_d = RUN;
                hit_d   = 1'b0;
                ovf_d   = 1'b0;
            end
            RUN: begin
                if (cnt_x_c && (bus.cnt_val == CNT_MAX)) begin
                    ovf_d = 1'b1;
                end
                // cnt_x is low on the exit cycle, so cnt_val is already the final count.
                if (lim_hit_c || bus.stop) begin
                    state_d    = REPORT;
                    rd_data_d  = bus.cnt_val;
                    hit_d      = lim_hit_c;
                    rd_valid_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            REPORT: begin
                if (bus.rd_ack) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            limit_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            hit_q      <= hit_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // Counter controls are combinational so the counter sees them in the same cycle.
    assign bus.cnt_x    = cnt_x_c;
    assign bus.cnt_clr  = (state_q == CLR) || !reset;
    assign bus.busy     = busy_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.hit      = hit_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_bcd_gate_ctrl.sv
// Scoreboard bench for bcd_gate_ctrl: a driver predicts each window's result from the
// counting rules and queues it; a monitor compares whenever rd_valid rises.
module tb_bcd_gate_ctrl;
    logic clk;
    logic reset;

    bcd_gate_ctrl_if bus ();

    bcd_gate_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int data;
        int hit;
        int ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [7:0] cnt_r;
    bit   rv_prev = 1'b0;
    exp_t held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural two-digit counter attached to the controller.
    always_ff @(posedge clk) begin
        if (bus.cnt_clr === 1'b1)     cnt_r <= 8'd0;
        else if (bus.cnt_x === 1'b1)  cnt_r <= (cnt_r == 8'd99) ? 8'd0 : cnt_r + 8'd1;
    end
    assign bus.cnt_val = cnt_r;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result comparison on each rd_valid rise; stability check while it is held.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1 && !rv_prev) begin
            if (sb_q.size() == 0) begin
                check("rd_valid_unexpected", 1, 0);
            end else begin
                held = sb_q.pop_front();
                check("rd_data", int'(bus.rd_data), held.data);
                check("hit", int'(bus.hit), held.hit);
                check("ovf", int'(bus.ovf), held.ovf);
            end
        end else if (bus.rd_valid === 1'b1 && rv_prev) begin
            check("rd_data_hold", int'(bus.rd_data), held.data);
            check("hit_hold", int'(bus.hit), held.hit);
        end
        if (bus.busy === 1'b0) check("cnt_x_idle", int'(bus.cnt_x), 0);
        rv_prev = (bus.rd_valid === 1'b1);
    end

    // One full window: start, count per the rules, report, ack, then a stray ack in IDLE.
    task automatic run_window(input int lim_in, input int prob, input int stop_at);
        int  cnt;
        int  eovf;
        int  ehit;
        bit  lim;
        bit  done;
        bit  e;
        bit  s;
        bus.start = 1'b1;
        bus.limit = 8'(lim_in);
        tick();
        bus.start = 1'b0;
        bus.limit = 8'($urandom);
        bus.stop  = 1'($urandom);
        bus.ev    = 1'($urandom);
        #1;
        check("busy_clr", int'(bus.busy), 1);
        check("cnt_clr_clr", int'(bus.cnt_clr), 1);
        check("cnt_x_clr", int'(bus.cnt_x), 0);
        tick();
        cnt  = 0;
        eovf = 0;
        ehit = 0;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            e = (($urandom % 100) < prob);
            s = (k == stop_at);
            bus.ev    = e;
            bus.stop  = s;
            bus.start = (($urandom % 8) == 0);
            lim = (lim_in <= 99) && (cnt == lim_in);
            #1;
            check("cnt_x_run", int'(bus.cnt_x), int'(e && !s && !lim));
            if (k == 0) check("busy_run", int'(bus.busy), 1);
            if (lim || s) begin
                ehit = lim ? 1 : 0;
                sb_q.push_back('{data: cnt, hit: ehit, ovf: eovf});
                done = 1'b1;
            end else if (e) begin
                if (cnt == 99) eovf = 1;
                cnt = (cnt + 1) % 100;
            end
            tick();
        end
        if (!done) check("window_timeout", 0, 1);
        bus.ev    = 1'b0;
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check("rd_valid_latency", int'(bus.rd_valid), 1);
        check("busy_report", int'(bus.busy), 0);
        repeat ($urandom_range(0, 3)) begin
            bus.start = 1'($urandom);
            bus.stop  = 1'($urandom);
            tick();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("rd_valid_before_ack", int'(bus.rd_valid), 1);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        check("rd_valid_after_ack", int'(bus.rd_valid), 0);
        check("rd_data_after_ack", int'(bus.rd_data), cnt);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        check("busy_idle", int'(bus.busy), 0);
        check("hit_idle_hold", int'(bus.hit), ehit);
        check("ovf_idle_hold", int'(bus.ovf), eovf);
    endtask

    initial begin
        int l;
        int sel;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.ev     = 1'b0;
        bus.limit  = 8'd0;
        bus.rd_ack = 1'b0;
        #2;
        check("cnt_clr_in_reset", int'(bus.cnt_clr), 1);
        repeat (2) tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_rd_data", int'(bus.rd_data), 0);
        check("rst_hit", int'(bus.hit), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_cnt_x", int'(bus.cnt_x), 0);

        // Start on the very first edge after reset release.
        reset = 1'b1;
        run_window(7, 100, 1000);
        run_window(50, 100, 12);
        run_window(200, 100, 105);
        run_window(0, 100, 1000);
        run_window(3, 100, 3);

        for (int i = 0; i < 25; i++) begin
            sel = $urandom % 4;
            if (sel == 0)      l = $urandom_range(0, 9);
            else if (sel == 1) l = $urandom_range(10, 99);
            else if (sel == 2) l = $urandom_range(100, 255);
            else               l = 99;
            run_window(l, $urandom_range(20, 100), $urandom_range(0, 230));
        end

        // Reset in the middle of a window discards it.
        bus.start = 1'b1;
        bus.limit = 8'd50;
        tick();
        bus.start = 1'b0;
        tick();
        bus.ev = 1'b1;
        repeat (4) tick();
        check("cnt_val_at_abort", int'(bus.cnt_val), 4);
        reset = 1'b0;
        #1;
        check("cnt_clr_reset_run", int'(bus.cnt_clr), 1);
        tick();
        check("abort_busy", int'(bus.busy), 0);
        check("abort_rd_valid", int'(bus.rd_valid), 0);
        check("abort_rd_data", int'(bus.rd_data), 0);
        check("abort_hit", int'(bus.hit), 0);
        check("abort_ovf", int'(bus.ovf), 0);
        check("abort_cnt_x", int'(bus.cnt_x), 0);
        check("abort_cnt_clr", int'(bus.cnt_clr), 1);
        reset  = 1'b1;
        bus.ev = 1'b0;
        repeat (5) tick();
        check("abort_no_valid", int'(bus.rd_valid), 0);

        repeat (3) tick();
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
